register_bank_sb: RTL and testbench

- Parametrised successor of the 16x32 register bank: DEPTH = 2**ADDR_W registers of DATA_W bits.
- Two asynchronous read ports (A, B) and one synchronous write port.
- Same-cycle write-to-read bypass.
- Per-register scoreboard (busy bits) so the issue stage detects RAW/WAW hazards and stalls until writeback.
- Sits between decode/issue and writeback in the processor datapath.

---
 rtl/register_bank_sb.sv | 128 ++++++++++++
 tb/tb_register_bank_sb.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/register_bank_sb.sv
// register_bank_sb
//   Parametrised register bank with a per-register scoreboard. DEPTH = 2**ADDR_W
//   registers of DATA_W bits, two combinational read ports with same-cycle write
//   bypass, one synchronous write port, and busy bits that let the issue stage
//   detect RAW/WAW hazards and stall until writeback resolves them.
//
//   Optional feature macro: REG_ZERO_EN
//     defined   -> register 0 is hardwired to zero, never written, never busy.
//     undefined -> register 0 behaves like every other register.
//
//   Ports
//     CLK       in   1         clock, all state updates on rising edge
//     RESET     in   1         synchronous active-high reset
//     RA, RB    in   ADDR_W    read indices for ports A and B
//     PRA, PRB  out  DATA_W    read data for ports A and B (zero latency)
//     WC        in   ADDR_W    write index
//     WPC       in   DATA_W    write data
//     W_RB      in   1         write enable
//     ISSUE     in   1         issue request, marks ISSUE_RD pending
//     ISSUE_RD  in   ADDR_W    destination register of the issuing instruction
//     BUSY_A/B  out  1         RA/RB has a pending write not resolved this cycle
//     STALL     out  1         issue must not proceed this cycle
//     PENDING   out  ADDR_W+1  number of busy registers
//
//   Issue handshake: ISSUE is the request, STALL is the back-pressure. An issue
//   is accepted on a rising CLK exactly when ISSUE=1 and STALL=0 in that cycle;
//   a stalled request has no state effect and may be held or withdrawn freely.
module register_bank_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    output logic [DATA_W-1:0] PRA,
    output logic [DATA_W-1:0] PRB,
    input  logic [ADDR_W-1:0] WC,
    input  logic [DATA_W-1:0] WPC,
    input  logic              W_RB,
    input  logic              ISSUE,
    input  logic [ADDR_W-1:0] ISSUE_RD,
    output logic              BUSY_A,
    output logic              BUSY_B,
    output logic              STALL,
    output logic [ADDR_W:0]   PENDING
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [ADDR_W:0]   pending_q;
    logic [ADDR_W:0]   pending_n;

    // Resolution hits: a write in flight this cycle resolves the busy bit of
    // its target, so readers of that register do not need to wait.
    logic hit_a;
    logic hit_b;
    logic hit_rd;

    logic wr_en;      // write that actually updates state
    logic issue_ok;   // accepted issue
    logic set_en;     // accepted issue that actually sets a busy bit
    logic inc;
    logic dec;

    assign hit_a  = W_RB && (WC == RA);
    assign hit_b  = W_RB && (WC == RB);
    assign hit_rd = W_RB && (WC == ISSUE_RD);

`ifdef REG_ZERO_EN
    assign wr_en  = W_RB && (WC != '0);
    assign set_en = issue_ok && (ISSUE_RD != '0);
`else
    assign wr_en  = W_RB;
    assign set_en = issue_ok;
`endif

    // Read ports with bypass; register 0 reads as zero when hardwired.
    always_comb begin
        PRA = regs[RA];
        PRB = regs[RB];
        if (hit_a) PRA = WPC;
        if (hit_b) PRB = WPC;
`ifdef REG_ZERO_EN
        if (RA == '0) PRA = '0;
        if (RB == '0) PRB = '0;
`endif
    end

    assign BUSY_A   = busy[RA] && !hit_a;
    assign BUSY_B   = busy[RB] && !hit_b;
    assign STALL    = ISSUE && (BUSY_A || BUSY_B || (busy[ISSUE_RD] && !hit_rd));
    assign issue_ok = ISSUE && !STALL;

    // An accepted issue can only target a register that is free or being
    // cleared this cycle. Issuing onto a register being cleared keeps its busy
    // bit set, so neither the increment nor the decrement applies.
    assign inc = set_en && !busy[ISSUE_RD];
    assign dec = wr_en && busy[WC] && !(set_en && (ISSUE_RD == WC));

    always_comb begin
        pending_n = pending_q;
        if (inc && !dec)      pending_n = pending_q + ONE;
        else if (dec && !inc) pending_n = pending_q - ONE;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            busy      <= '0;
            pending_q <= '0;
        end else begin
            if (wr_en) begin
                regs[WC] <= WPC;
                busy[WC] <= 1'b0;
            end
            // Placed after the clear so a same-edge issue to WC wins.
            if (set_en) busy[ISSUE_RD] <= 1'b1;
            pending_q <= pending_n;
        end
    end

    assign PENDING = pending_q;

endmodule

// File: tb/tb_register_bank_sb.sv
// Bench for register_bank_sb: directed scenarios with literal expectations, then
// randomized traffic. A reference model (array of values, array of busy flags,
// pending = number of set flags) predicts every output each cycle.
module tb_register_bank_sb;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] ra = '0, rb = '0, wc = '0, ird = '0;
    logic [DW-1:0] wpc = '0;
    logic          wrb = 1'b0, iss = 1'b0;
    logic [DW-1:0] pra, prb;
    logic          busy_a, busy_b, stall;
    logic [AW:0]   pending;

    int n_checks = 0;
    int n_fail   = 0;

    register_bank_sb #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .CLK(clk), .RESET(rst), .RA(ra), .RB(rb), .PRA(pra), .PRB(prb),
        .WC(wc), .WPC(wpc), .W_RB(wrb), .ISSUE(iss), .ISSUE_RD(ird),
        .BUSY_A(busy_a), .BUSY_B(busy_b), .STALL(stall), .PENDING(pending)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [DW-1:0] m_regs [DEPTH];
    bit            m_busy [DEPTH];
    bit            m_valid = 1'b0;

    function automatic bit zero_idx(input logic [AW-1:0] x);
`ifdef REG_ZERO_EN
        return x == '0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] x);
        if (zero_idx(x)) return '0;
        if (wrb && wc == x) return wpc;
        return m_regs[x];
    endfunction

    function automatic bit exp_busy(input logic [AW-1:0] x);
        return m_busy[x] && !(wrb && wc == x);
    endfunction

    function automatic bit exp_stall();
        return iss && (exp_busy(ra) || exp_busy(rb) || exp_busy(ird));
    endfunction

    function automatic int exp_pending();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) if (m_busy[i]) n++;
        return n;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
            m_valid = 1'b1;
        end else if (m_valid) begin
            bit accepted;
            accepted = iss && !exp_stall();
            if (wrb && !zero_idx(wc)) begin
                m_regs[wc] = wpc;
                m_busy[wc] = 1'b0;
            end
            if (accepted && !zero_idx(ird)) m_busy[ird] = 1'b1;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Single compare process: mid-cycle, after inputs have settled.
    always @(negedge clk) begin
        if (m_valid && !rst) begin
            chk("pra",     pra, exp_read(ra));
            chk("prb",     prb, exp_read(rb));
            chk("busy_a",  {31'd0, busy_a}, {31'd0, exp_busy(ra)});
            chk("busy_b",  {31'd0, busy_b}, {31'd0, exp_busy(rb)});
            chk("stall",   {31'd0, stall},  {31'd0, exp_stall()});
            chk("pending", {27'd0, pending}, DW'(exp_pending()));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [AW-1:0] c,
                         input logic [DW-1:0] d, input logic i, input logic [AW-1:0] rd,
                         input logic [AW-1:0] a, input logic [AW-1:0] b);
        rst = r; wrb = w; wc = c; wpc = d; iss = i; ird = rd; ra = a; rb = b;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, ra, rb);
    endtask

    // ---------------- stimulus ----------------
    logic [DW-1:0] fill [DEPTH];

    initial begin
        // reset
        drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0);
        tick();
        idle();
        #2;
        chk("rst_pra", pra, '0);
        chk("rst_prb", prb, '0);
        chk("rst_pending", {27'd0, pending}, '0);
        chk("rst_stall", {31'd0, stall}, '0);

        // fill every register
        for (int i = 0; i < DEPTH; i++) begin
            fill[i] = $urandom;
            drive(1'b0, 1'b1, AW'(i), fill[i], 1'b0, '0, '0, '0);
            tick();
        end
        idle();
        for (int i = 1; i < DEPTH - 1; i++) begin
            ra = AW'(i); rb = AW'(i + 1);
            #2;
            chk("fill_pra", pra, fill[i]);
            chk("fill_prb", prb, fill[i + 1]);
            tick();
        end

        // bypass
        drive(1'b0, 1'b1, 4'd3, 32'h1111_1111, 1'b0, '0, 4'd0, 4'd0);
        tick();
        drive(1'b0, 1'b1, 4'd3, 32'hDEAD_BEEF, 1'b0, '0, 4'd3, 4'd3);
        #2;
        chk("bypass_pra", pra, 32'hDEAD_BEEF);
        chk("bypass_prb", prb, 32'hDEAD_BEEF);
        tick();
        idle();
        #2;
        chk("bypass_after", pra, 32'hDEAD_BEEF);
        tick();

        // RAW stall on register 5
        drive(1'b0, 1'b0, '0, '0, 1'b1, 4'd5, 4'd0, 4'd0);
        #2;
        chk("raw_issue_stall", {31'd0, stall}, '0);
        tick();
        drive(1'b0, 1'b0, '0, '0, 1'b1, 4'd6, 4'd5, 4'd1);
        #2;
        chk("raw_pending1", {27'd0, pending}, 32'd1);
        chk("raw_busy_a", {31'd0, busy_a}, 32'd1);
        chk("raw_stall", {31'd0, stall}, 32'd1);
        tick();
        chk("raw_pending_hold", {27'd0, pending}, 32'd1);
        drive(1'b0, 1'b1, 4'd5, 32'h0000_0042, 1'b0, '0, 4'd5, 4'd1);
        #2;
        chk("raw_busy_a_clr", {31'd0, busy_a}, '0);
        chk("raw_stall_clr", {31'd0, stall}, '0);
        chk("raw_pra", pra, 32'h0000_0042);
        tick();
        idle();
        #2;
        chk("raw_pending0", {27'd0, pending}, '0);
        tick();

        // simultaneous issue and writeback on register 7
        drive(1'b0, 1'b0, '0, '0, 1'b1, 4'd7, 4'd0, 4'd0);
        tick();
        drive(1'b0, 1'b1, 4'd7, 32'hCAFE_0007, 1'b1, 4'd7, 4'd0, 4'd0);
        #2;
        chk("sim_stall", {31'd0, stall}, '0);
        tick();
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 4'd7, 4'd7);
        #2;
        chk("sim_pending", {27'd0, pending}, 32'd1);
        chk("sim_pra", pra, 32'hCAFE_0007);
        chk("sim_busy_a", {31'd0, busy_a}, 32'd1);
        tick();
        drive(1'b0, 1'b1, 4'd7, 32'hCAFE_0007, 1'b0, '0, 4'd7, 4'd7);
        tick();

        // reset mid-operation
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 1'b0, '0, '0, 1'b1, AW'(i), 4'd0, 4'd0);
            tick();
        end
        idle();
        #2;
        chk("mid_pending3", {27'd0, pending}, 32'd3);
        drive(1'b1, 1'b1, 4'd2, 32'h1234_5678, 1'b1, 4'd4, 4'd1, 4'd2);
        tick();
        drive(1'b0, 1'b0, '0, '0, 1'b1, 4'd1, 4'd2, 4'd3);
        #2;
        chk("mid_pending0", {27'd0, pending}, '0);
        chk("mid_pra", pra, '0);
        chk("mid_prb", prb, '0);
        chk("mid_stall", {31'd0, stall}, '0);
        tick();
        idle();
        tick();

`ifdef REG_ZERO_EN
        drive(1'b0, 1'b1, 4'd0, 32'hFFFF_FFFF, 1'b0, '0, 4'd0, 4'd0);
        #2;
        chk("z_bypass", pra, '0);
        tick();
        drive(1'b0, 1'b0, '0, '0, 1'b1, 4'd0, 4'd0, 4'd0);
        #2;
        chk("z_pra", pra, '0);
        tick();
        #2;
        chk("z_pending", {27'd0, pending}, {27'd0, 5'd1} & 32'd0 | DW'(exp_pending()));
        chk("z_busy_a", {31'd0, busy_a}, '0);
        tick();
        idle();
        tick();
`endif

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 99) == 0), $urandom_range(0, 1),
                  AW'($urandom_range(0, DEPTH - 1)), $urandom,
                  $urandom_range(0, 1), AW'($urandom_range(0, DEPTH - 1)),
                  AW'($urandom_range(0, DEPTH - 1)), AW'($urandom_range(0, DEPTH - 1)));
            if ($urandom_range(0, 7) == 0) rb = ra;
            if ($urandom_range(0, 7) == 0) wc = ra;
            if ($urandom_range(0, 7) == 0) ird = wc;
            #2;
            if (pending > 5'(DEPTH)) chk("pending_range", {27'd0, pending}, 32'd16);
            tick();
        end
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
